// File: rtl/multicycle_control_unit_pkg.sv
// Purpose: shared encodings for the multicycle RV32I control unit. This covers
//          FSM states, ALU operations, datapath select codes, RV32I opcodes,
//          fault codes, flag bit positions and the branch-condition helper.
package multicycle_control_unit_pkg;

  localparam int unsigned OPC_W     = 7;
  localparam int unsigned F3_W      = 3;
  localparam int unsigned FLAGS_W   = 4;
  localparam int unsigned ALUCTRL_W = 4;
  localparam int unsigned IMMSRC_W  = 3;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned FCODE_W   = 2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB, S_EXEC_R,
    S_EXEC_I, S_JAL, S_JALR, S_BRANCH, S_UPPER, S_ALUWB, S_FAULT
  } state_e;

  // Coarse ALU intent from the FSM; refined by the ALU decoder.
  typedef enum logic [2:0] {
    ALUOP_ADD, ALUOP_SUB, ALUOP_R, ALUOP_I, ALUOP_PASSB
  } alu_op_e;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALUCTRL_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALUCTRL_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALUCTRL_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALUCTRL_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALUCTRL_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALUCTRL_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALUCTRL_W-1:0] ALU_PASSB = 4'd10;

  localparam logic [IMMSRC_W-1:0] IMM_I = 3'd0;
  localparam logic [IMMSRC_W-1:0] IMM_S = 3'd1;
  localparam logic [IMMSRC_W-1:0] IMM_B = 3'd2;
  localparam logic [IMMSRC_W-1:0] IMM_J = 3'd3;
  localparam logic [IMMSRC_W-1:0] IMM_U = 3'd4;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'd0;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'd1;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'd2;
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] RES_MEM    = 2'd1;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'd2;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [FCODE_W-1:0] FAULT_NONE    = 2'd0;
  localparam logic [FCODE_W-1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [FCODE_W-1:0] FAULT_BUS     = 2'd2;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Branch outcome from the rs1-rs2 flags; C=1 means no borrow.
  function automatic logic branch_taken(input logic [F3_W-1:0] f3,
                                        input logic [FLAGS_W-1:0] flags);
    logic lt;
    lt = flags[FLAG_N] ^ flags[FLAG_V];
    case (f3)
      3'b000:  branch_taken = flags[FLAG_Z];
      3'b001:  branch_taken = !flags[FLAG_Z];
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = !lt;
      3'b110:  branch_taken = !flags[FLAG_C];
      3'b111:  branch_taken = flags[FLAG_C];
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Purpose: combinational ALU-control decode.
// Ports:   i_alu_op (FSM intent), i_funct3, i_funct7_b5 -> o_alu_control_c.
module multicycle_control_unit_alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  alu_op_e              i_alu_op,
  input  logic [F3_W-1:0]      i_funct3,
  input  logic                 i_funct7_b5,
  output logic [ALUCTRL_W-1:0] o_alu_control_c
);

  always_comb begin
    o_alu_control_c = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB:   o_alu_control_c = ALU_SUB;
      ALUOP_PASSB: o_alu_control_c = ALU_PASSB;
      ALUOP_R, ALUOP_I: begin
        case (i_funct3)
          // funct7_b5 selects SUB only for register-register; ADDI has imm bits there
          3'b000: o_alu_control_c = (i_alu_op == ALUOP_R && i_funct7_b5) ? ALU_SUB : ALU_ADD;
          3'b001: o_alu_control_c = ALU_SLL;
          3'b010: o_alu_control_c = ALU_SLT;
          3'b011: o_alu_control_c = ALU_SLTU;
          3'b100: o_alu_control_c = ALU_XOR;
          3'b101: o_alu_control_c = i_funct7_b5 ? ALU_SRA : ALU_SRL;
          3'b110: o_alu_control_c = ALU_OR;
          default: o_alu_control_c = ALU_AND;
        endcase
      end
      default: o_alu_control_c = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: multicycle RV32I control FSM over one shared memory port and one ALU.
//          It adds a memory-ready handshake, bus-timeout and illegal-opcode faults,
//          and a retired-instruction counter.
// Ports:   clk, rst_n; IR fields i_opcode/i_funct3/i_funct7_b5; i_alu_flags {N,Z,C,V};
//          i_mem_ready. Outputs are datapath selects and enables, plus o_retire,
//          o_instret, o_fault and o_fault_code.
//          Selects and enables are combinational from state and IR fields.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPC_W-1:0]     i_opcode,
  input  logic [F3_W-1:0]      i_funct3,
  input  logic                 i_funct7_b5,
  input  logic [FLAGS_W-1:0]   i_alu_flags,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic                 o_adr_src,
  output logic                 o_ir_write,
  output logic                 o_pc_write,
  output logic                 o_reg_write,
  output logic [IMMSRC_W-1:0]  o_imm_src,
  output logic [SEL_W-1:0]     o_alu_src_a,
  output logic [SEL_W-1:0]     o_alu_src_b,
  output logic [SEL_W-1:0]     o_result_src,
  output logic [ALUCTRL_W-1:0] o_alu_control,
  output logic [1:0]           o_mask_type,
  output logic                 o_ext_type,
  output logic                 o_retire,
  output logic [CNT_W-1:0]     o_instret,
  output logic                 o_fault,
  output logic [FCODE_W-1:0]   o_fault_code
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e               r_state, w_next_state;
  alu_op_e              w_alu_op;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [FCODE_W-1:0]   r_fault_code, w_fault_code;
  logic [CNT_W-1:0]     r_instret;
  logic                 w_timeout;
  logic                 w_taken;
  logic                 w_branch_legal;

  // Last tolerated unacknowledged cycle of a request.
  assign w_timeout      = !i_mem_ready && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
  assign w_taken        = branch_taken(i_funct3, i_alu_flags);
  assign w_branch_legal = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);

  multicycle_control_unit_alu_decoder u_alu_dec (
    .i_alu_op        (w_alu_op),
    .i_funct3        (i_funct3),
    .i_funct7_b5     (i_funct7_b5),
    .o_alu_control_c (o_alu_control)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next state and outputs; held at all-zero while rst_n is low so a reset mid-access drops the request at once.
  always_comb begin
    w_next_state = r_state;
    w_fault_code = FAULT_NONE;
    w_alu_op     = ALUOP_ADD;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_reg_write  = 1'b0;
    o_retire     = 1'b0;
    o_imm_src    = IMM_I;
    o_alu_src_a  = SRCA_PC;
    o_alu_src_b  = SRCB_RS2;
    o_result_src = RES_ALUOUT;
    o_mask_type  = 2'b00;
    o_ext_type   = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_alu_src_b = SRCB_FOUR;
          if (i_mem_ready) begin
            o_ir_write   = 1'b1;
            o_pc_write   = 1'b1;
            w_next_state = S_DECODE;
          end else if (w_timeout) begin
            w_next_state = S_FAULT;
            w_fault_code = FAULT_BUS;
          end
        end
        S_DECODE: begin
          // Precompute the PC-relative target; JAL needs the J-format immediate.
          o_alu_src_a = SRCA_OLDPC;
          o_alu_src_b = SRCB_IMM;
          o_imm_src   = (i_opcode == OPC_JAL) ? IMM_J : IMM_B;
          case (i_opcode)
            OPC_LOAD, OPC_STORE: w_next_state = S_MEMADR;
            OPC_OP:              w_next_state = S_EXEC_R;
            OPC_OP_IMM:          w_next_state = S_EXEC_I;
            OPC_JAL:             w_next_state = S_JAL;
            OPC_JALR:            w_next_state = S_JALR;
            OPC_BRANCH:          w_next_state = S_BRANCH;
            OPC_LUI, OPC_AUIPC:  w_next_state = S_UPPER;
            default: begin
              w_next_state = S_FAULT;
              w_fault_code = FAULT_ILLEGAL;
            end
          endcase
        end
        S_MEMADR: begin
          o_alu_src_a  = SRCA_RS1;
          o_alu_src_b  = SRCB_IMM;
          o_imm_src    = (i_opcode == OPC_STORE) ? IMM_S : IMM_I;
          w_next_state = (i_opcode == OPC_LOAD) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          o_mem_req   = 1'b1;
          o_adr_src   = 1'b1;
          o_mask_type = i_funct3[1:0];
          o_ext_type  = i_funct3[2];
          if (i_mem_ready) begin
            w_next_state = S_MEMWB;
          end else if (w_timeout) begin
            w_next_state = S_FAULT;
            w_fault_code = FAULT_BUS;
          end
        end
        S_MEMWR: begin
          o_mem_req   = 1'b1;
          o_mem_we    = 1'b1;
          o_adr_src   = 1'b1;
          o_mask_type = i_funct3[1:0];
          if (i_mem_ready) begin
            o_retire     = 1'b1;
            w_next_state = S_FETCH;
          end else if (w_timeout) begin
            w_next_state = S_FAULT;
            w_fault_code = FAULT_BUS;
          end
        end
        S_MEMWB: begin
          o_result_src = RES_MEM;
          o_mask_type  = i_funct3[1:0];
          o_ext_type   = i_funct3[2];
          o_reg_write  = 1'b1;
          o_retire     = 1'b1;
          w_next_state = S_FETCH;
        end
        S_EXEC_R: begin
          o_alu_src_a  = SRCA_RS1;
          w_alu_op     = ALUOP_R;
          w_next_state = S_ALUWB;
        end
        S_EXEC_I: begin
          o_alu_src_a  = SRCA_RS1;
          o_alu_src_b  = SRCB_IMM;
          w_alu_op     = ALUOP_I;
          w_next_state = S_ALUWB;
        end
        S_JAL: begin
          // Target sits in ALUOut from DECODE; ALU forms the link value OldPC+4.
          o_alu_src_a  = SRCA_OLDPC;
          o_alu_src_b  = SRCB_FOUR;
          o_pc_write   = 1'b1;
          w_next_state = S_ALUWB;
        end
        S_JALR: begin
          o_alu_src_a  = SRCA_RS1;
          o_alu_src_b  = SRCB_IMM;
          o_result_src = RES_ALU;
          o_pc_write   = 1'b1;
          w_next_state = S_ALUWB;
        end
        S_UPPER: begin
          o_imm_src    = IMM_U;
          o_alu_src_b  = SRCB_IMM;
          if (i_opcode == OPC_LUI) w_alu_op = ALUOP_PASSB;
          else                     o_alu_src_a = SRCA_OLDPC;
          w_next_state = S_ALUWB;
        end
        S_BRANCH: begin
          o_alu_src_a  = SRCA_RS1;
          w_alu_op     = ALUOP_SUB;
          if (w_branch_legal) begin
            o_pc_write   = w_taken;
            o_retire     = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_FAULT;
            w_fault_code = FAULT_ILLEGAL;
          end
        end
        S_ALUWB: begin
          o_reg_write  = 1'b1;
          o_retire     = 1'b1;
          w_next_state = S_FETCH;
        end
        S_FAULT: w_next_state = S_FAULT;
        default: begin
          w_next_state = S_FAULT;
          w_fault_code = FAULT_ILLEGAL;
        end
      endcase
    end
  end

  // Fault code captured on entry to FAULT and held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          r_fault_code <= FAULT_NONE;
    else if (w_next_state == S_FAULT && r_state != S_FAULT) r_fault_code <= w_fault_code;
  end

  // Unacknowledged-request cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                   r_wait_cnt <= '0;
    else if (!o_mem_req || i_mem_ready || w_next_state != r_state) r_wait_cnt <= '0;
    else                                                          r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instret <= '0;
    else if (o_retire) r_instret <= r_instret + CNT_W'(1);
  end

  assign o_instret    = r_instret;
  assign o_fault      = (r_state == S_FAULT);
  assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
  logic [2:0] imm_src;
  logic [1:0] alu_src_a, alu_src_b, result_src, mask_type, fault_code;
  logic [3:0] alu_control;
  logic       ext_type, retire, fault;
  logic [3:0] instret;

  int n_tests = 0;
  int n_fail  = 0;
  int c_req, c_we, c_ir, c_rw, c_cyc;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BR = 7'b1100011,
                         OP_LUI = 7'b0110111;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3), .i_funct7_b5(funct7_b5),
    .i_alu_flags(alu_flags), .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_adr_src(adr_src), .o_ir_write(ir_write), .o_pc_write(pc_write), .o_reg_write(reg_write),
    .o_imm_src(imm_src), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_result_src(result_src), .o_alu_control(alu_control), .o_mask_type(mask_type),
    .o_ext_type(ext_type), .o_retire(retire), .o_instret(instret), .o_fault(fault),
    .o_fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    c_req = 0; c_we = 0; c_ir = 0; c_rw = 0; c_cyc = 0;
  endtask

  // Tally this cycle's strobes, then move to 1 time unit past the next rising edge.
  task automatic adv();
    if (mem_req)   c_req++;
    if (mem_we)    c_we++;
    if (ir_write)  c_ir++;
    if (reg_write) c_rw++;
    c_cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin #1; adv(); end
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    opcode = o; funct3 = f3; funct7_b5 = f7;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; alu_flags = 4'b0000;
    set_ir(OP_R, 3'b000, 1'b0);
    clr_cnt();
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_code", 32'(fault_code), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD: FETCH, DECODE, EXEC_R, ALUWB
    clr_cnt();
    #1;
    chk("add_fetch_req", 32'(mem_req), 32'd1);
    chk("add_fetch_irw", 32'(ir_write), 32'd1);
    chk("add_fetch_pcw", 32'(pc_write), 32'd1);
    chk("add_fetch_srcb", 32'(alu_src_b), 32'd2);
    adv(); #1;
    chk("add_dec_srca", 32'(alu_src_a), 32'd1);
    chk("add_dec_imm", 32'(imm_src), 32'd2);
    chk("add_dec_req", 32'(mem_req), 32'd0);
    adv(); #1;
    chk("add_exr_srca", 32'(alu_src_a), 32'd2);
    chk("add_exr_alu", 32'(alu_control), 32'd0);
    chk("add_exr_retire", 32'(retire), 32'd0);
    adv(); #1;
    chk("add_wb_regw", 32'(reg_write), 32'd1);
    chk("add_wb_retire", 32'(retire), 32'd1);
    adv(); #1;
    chk("add_instret", 32'(instret), 32'd1);
    chk("add_cpi", 32'(c_cyc), 32'd4);
    chk("add_back_fetch", 32'(mem_req), 32'd1);

    // SUB (funct7_b5 applies to OP)
    set_ir(OP_R, 3'b000, 1'b1);
    run(2); #1;
    chk("sub_alu", 32'(alu_control), 32'd1);
    adv(); run(1);
    // ADDI with imm bit 30 set stays ADD
    set_ir(OP_I, 3'b000, 1'b1);
    run(2); #1;
    chk("addi_alu", 32'(alu_control), 32'd0);
    chk("addi_srcb", 32'(alu_src_b), 32'd1);
    adv(); run(1);
    // SRAI
    set_ir(OP_I, 3'b101, 1'b1);
    run(2); #1;
    chk("srai_alu", 32'(alu_control), 32'd7);
    adv(); run(1);
    #1; chk("instret_4", 32'(instret), 32'd4);

    // LW with 3 not-ready cycles in MEMRD
    set_ir(OP_LOAD, 3'b010, 1'b0);
    clr_cnt();
    run(2); #1;
    chk("lw_madr_srca", 32'(alu_src_a), 32'd2);
    chk("lw_madr_imm", 32'(imm_src), 32'd0);
    adv();
    mem_ready = 1'b0;
    repeat (3) begin
      #1;
      chk("lw_memrd_req", 32'(mem_req), 32'd1);
      chk("lw_memrd_adr", 32'(adr_src), 32'd1);
      adv();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_memrd_mask", 32'(mask_type), 32'd2);
    adv(); #1;
    chk("lw_wb_res", 32'(result_src), 32'd1);
    chk("lw_wb_retire", 32'(retire), 32'd1);
    adv(); #1;
    chk("lw_req_cycles", 32'(c_req), 32'd5);  // 1 in FETCH + 4 in MEMRD
    chk("lw_regw_once", 32'(c_rw), 32'd1);
    chk("lw_cpi", 32'(c_cyc), 32'd8);
    chk("lw_instret", 32'(instret), 32'd5);

    // SW: CPI 4, retires from MEMWR
    set_ir(OP_STORE, 3'b010, 1'b0);
    clr_cnt();
    run(2); #1;
    chk("sw_madr_imm", 32'(imm_src), 32'd1);
    adv(); #1;
    chk("sw_memwr_we", 32'(mem_we), 32'd1);
    chk("sw_memwr_retire", 32'(retire), 32'd1);
    adv(); #1;
    chk("sw_cpi", 32'(c_cyc), 32'd4);
    chk("sw_no_regw", 32'(c_rw), 32'd0);
    chk("sw_instret", 32'(instret), 32'd6);

    // BLT taken (N=1,V=0) and not taken (N=1,V=1)
    set_ir(OP_BR, 3'b100, 1'b0);
    alu_flags = 4'b1000;
    run(2); #1;
    chk("blt_t_alu", 32'(alu_control), 32'd1);
    chk("blt_t_pcw", 32'(pc_write), 32'd1);
    chk("blt_t_retire", 32'(retire), 32'd1);
    adv();
    alu_flags = 4'b1001;
    run(2); #1;
    chk("blt_n_pcw", 32'(pc_write), 32'd0);
    chk("blt_n_retire", 32'(retire), 32'd1);
    adv();
    // BGEU with borrow (C=0) not taken
    set_ir(OP_BR, 3'b111, 1'b0);
    alu_flags = 4'b0000;
    run(2); #1;
    chk("bgeu_pcw", 32'(pc_write), 32'd0);
    adv(); #1;
    chk("br_instret", 32'(instret), 32'd9);

    // JAL and LUI
    set_ir(OP_JAL, 3'b000, 1'b0);
    run(1); #1;
    chk("jal_dec_imm", 32'(imm_src), 32'd3);
    adv(); #1;
    chk("jal_pcw", 32'(pc_write), 32'd1);
    chk("jal_srcb", 32'(alu_src_b), 32'd2);
    adv(); #1;
    chk("jal_wb_regw", 32'(reg_write), 32'd1);
    adv();
    set_ir(OP_LUI, 3'b000, 1'b0);
    run(2); #1;
    chk("lui_alu", 32'(alu_control), 32'd10);
    chk("lui_imm", 32'(imm_src), 32'd4);
    adv(); run(1);
    #1; chk("instret_11", 32'(instret), 32'd11);

    // Wrap of the 4-bit counter: 11 + 4 = 15, + 1 = 0
    set_ir(OP_R, 3'b000, 1'b0);
    run(16); #1;
    chk("instret_15", 32'(instret), 32'd15);
    run(4); #1;
    chk("instret_wrap", 32'(instret), 32'd0);

    // Reset asserted in the middle of a MEMWR wait
    set_ir(OP_STORE, 3'b000, 1'b0);
    run(3);
    mem_ready = 1'b0;
    #1;
    chk("midrst_pre_we", 32'(mem_we), 32'd1);
    #1; rst_n = 1'b0; #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Bus timeout in FETCH: 4 waiting cycles, then fault code 2
    clr_cnt();
    repeat (4) begin
      #1;
      chk("to_fetch_req", 32'(mem_req), 32'd1);
      adv();
    end
    #1;
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_code", 32'(fault_code), 32'd2);
    chk("to_req_dropped", 32'(mem_req), 32'd0);
    mem_ready = 1'b1;
    run(3); #1;
    chk("to_irw_never", 32'(c_ir), 32'd0);
    chk("to_req_total", 32'(c_req), 32'd4);
    do_reset();

    // Illegal opcode: DECODE then FAULT code 1, silent afterwards
    set_ir(7'b0000000, 3'b000, 1'b0);
    run(1); #1;
    chk("ill_dec_fault", 32'(fault), 32'd0);
    adv(); #1;
    chk("ill_fault", 32'(fault), 32'd1);
    chk("ill_code", 32'(fault_code), 32'd1);
    clr_cnt();
    run(20); #1;
    chk("ill_no_req", 32'(c_req), 32'd0);
    chk("ill_still_fault", 32'(fault_code), 32'd1);
    do_reset();

    // Reserved branch funct3: no pc_write, no retire, fault code 1
    set_ir(OP_BR, 3'b010, 1'b0);
    run(2); #1;
    chk("brill_pcw", 32'(pc_write), 32'd0);
    chk("brill_retire", 32'(retire), 32'd0);
    adv(); #1;
    chk("brill_code", 32'(fault_code), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
